clk_div_bank: RTL

Parametrised bank of independent clock dividers, all running on one source clock. Each channel produces a registered divided clock plus one-cycle rise/fall strobes in the `clk_in` domain, for use as clock enables. Every channel has a programmable divide ratio, glitch-free enable and disable, and ratio changes that only take effect at a period boundary. This block supersedes the fixed divide-by-2 gating generator for every consumer that needs more than one ratio or more than one channel.

---
 rtl/clk_div_bank.sv | 112 +++++++++++
 1 files changed

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers on one source clock.
// Each channel emits a registered divided clock plus rise/fall strobes usable as clock enables.
module clk_div_bank #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned DIV_RST = 2
) (
    input  logic                    clk_in,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*DIV_W-1:0] div_val,
    input  logic [NUM_CH-1:0]       div_load,
    input  logic                    sync_restart,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       rise_stb,
    output logic [NUM_CH-1:0]       fall_stb,
    output logic [NUM_CH-1:0]       ch_active
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state;
        logic [DIV_W-1:0] cnt, d, p;
        logic             p_vld, clk_q, rise_q, fall_q, act_q;
        logic [DIV_W-1:0] field, cap, eff_p, nxt_cnt, nxt_d;
        logic             eff_vld, wrap;
        logic [DIV_W:0]   nxt_h;

        // A same-cycle div_load counts as pending, so restart and wrap both see it.
        always_comb begin
            field   = div_val[i*DIV_W +: DIV_W];
            cap     = (field < DIV_W'(2)) ? DIV_W'(2) : field;
            eff_vld = div_load[i] | p_vld;
            eff_p   = div_load[i] ? cap : p;
            wrap    = (cnt == d - DIV_W'(1));
            nxt_cnt = wrap ? '0 : cnt + DIV_W'(1);
            nxt_d   = (wrap && eff_vld) ? eff_p : d;
            nxt_h   = ({1'b0, nxt_d} + (DIV_W+1)'(1)) >> 1;
        end

        always_ff @(posedge clk_in or negedge reset_n) begin
            if (!reset_n) begin
                state  <= IDLE;
                cnt    <= '0;
                d      <= DIV_W'(DIV_RST);
                p      <= '0;
                p_vld  <= 1'b0;
                clk_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                act_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (div_load[i]) begin
                    p     <= cap;
                    p_vld <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        cnt   <= '0;
                        clk_q <= 1'b0;
                        if (eff_vld) begin
                            d     <= eff_p;
                            p_vld <= 1'b0;
                        end
                        if (ch_en[i]) begin
                            state  <= RUN;
                            clk_q  <= 1'b1;
                            rise_q <= 1'b1;
                            act_q  <= 1'b1;
                        end
                    end
                    default: begin
                        if (sync_restart) begin
                            cnt    <= '0;
                            clk_q  <= 1'b1;
                            rise_q <= 1'b1;
                            state  <= ch_en[i] ? RUN : STOP;
                            if (eff_vld) begin
                                d     <= eff_p;
                                p_vld <= 1'b0;
                            end
                        end else if (state == STOP && wrap && !ch_en[i]) begin
                            state <= IDLE;
                            cnt   <= '0;
                            clk_q <= 1'b0;
                            act_q <= 1'b0;
                            d     <= nxt_d;
                            if (eff_vld) p_vld <= 1'b0;
                        end else begin
                            cnt    <= nxt_cnt;
                            d      <= nxt_d;
                            clk_q  <= ({1'b0, nxt_cnt} < nxt_h);
                            rise_q <= (nxt_cnt == '0);
                            fall_q <= ({1'b0, nxt_cnt} == nxt_h);
                            state  <= ch_en[i] ? RUN : STOP;
                            if (wrap && eff_vld) p_vld <= 1'b0;
                        end
                    end
                endcase
            end
        end

        assign clk_out[i]   = clk_q;
        assign rise_stb[i]  = rise_q;
        assign fall_stb[i]  = fall_q;
        assign ch_active[i] = act_q;
    end

endmodule
